// File: rtl/count_tracker.sv
// Monitor for a CW-bit up/down counter: classifies each sampled transition and
// derives direction, one-cycle wrap pulses, a signed net-lap count and a sticky error.
module count_tracker #(
  parameter int CW = 3,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count,
  input  logic          clr_err,
  output logic          primed,
  output logic          dir,
  output logic          wrap_up,
  output logic          wrap_down,
  output logic [LW-1:0] laps,
  output logic          step_err
);

  typedef enum logic {IDLE, TRACK} state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] prev_q, prev_d;
  logic [CW-1:0] delta;
  logic          primed_q, primed_d;
  logic          dir_q, dir_d;
  logic          wrap_up_q, wrap_up_d;
  logic          wrap_down_q, wrap_down_d;
  logic [LW-1:0] laps_q, laps_d;
  logic          step_err_q, step_err_d;

  // Subtraction truncated to CW bits gives the modular step distance directly.
  assign delta = count - prev_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no latch is inferred.
    state_d     = state_q;
    prev_d      = prev_q;
    primed_d    = primed_q;
    dir_d       = dir_q;
    wrap_up_d   = 1'b0;
    wrap_down_d = 1'b0;
    laps_d      = laps_q;
    step_err_d  = step_err_q & ~clr_err;

    case (state_q)
      IDLE: begin
        prev_d   = count;
        primed_d = 1'b1;
        state_d  = TRACK;
      end
      TRACK: begin
        prev_d = count;
        if (delta == CNT_ONE) begin
          dir_d = 1'b1;
          if (prev_q == CNT_MAX) begin
            wrap_up_d = 1'b1;
            laps_d    = laps_q + LW'(1);
          end
        end else if (delta == CNT_MAX) begin
          dir_d = 1'b0;
          if (prev_q == '0) begin
            wrap_down_d = 1'b1;
            laps_d      = laps_q - LW'(1);
          end
        end else if (delta != '0) begin
          // A coincident clear loses: the set overrides the cleared default above.
          step_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      primed_q    <= 1'b0;
      dir_q       <= 1'b0;
      wrap_up_q   <= 1'b0;
      wrap_down_q <= 1'b0;
      laps_q      <= '0;
      step_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      primed_q    <= primed_d;
      dir_q       <= dir_d;
      wrap_up_q   <= wrap_up_d;
      wrap_down_q <= wrap_down_d;
      laps_q      <= laps_d;
      step_err_q  <= step_err_d;
    end
  end

  assign primed    = primed_q;
  assign dir       = dir_q;
  assign wrap_up   = wrap_up_q;
  assign wrap_down = wrap_down_q;
  assign laps      = laps_q;
  assign step_err  = step_err_q;

endmodule

// File: tb/tb_count_tracker.sv
// Directed bench for count_tracker: a behavioural model pushes expected outputs
// to a scoreboard queue at drive time; they are popped and compared after each edge.
module tb_count_tracker;

  localparam int CW = 3;
  localparam int LW = 8;

  typedef struct packed {
    logic          primed;
    logic          dir;
    logic          wu;
    logic          wd;
    logic [LW-1:0] laps;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] count = '0;
  logic          clr_err = 1'b0;
  logic          primed, dir, wrap_up, wrap_down, step_err;
  logic [LW-1:0] laps;

  count_tracker #(.CW(CW), .LW(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .clr_err   (clr_err),
    .primed    (primed),
    .dir       (dir),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .laps      (laps),
    .step_err  (step_err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  // Reference model state
  bit            m_primed;
  int            m_prev;
  bit            m_dir;
  logic [LW-1:0] m_laps;
  bit            m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_state(input bit wu, input bit wd);
    exp_t e;
    e.primed = m_primed;
    e.dir    = m_dir;
    e.wu     = wu;
    e.wd     = wd;
    e.laps   = m_laps;
    e.err    = m_err;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_primed = 0;
    m_prev   = 0;
    m_dir    = 0;
    m_laps   = '0;
    m_err    = 0;
    push_state(0, 0);
  endtask

  task automatic model_edge(input int c, input bit clr);
    bit wu = 0;
    bit wd = 0;
    bit bad = 0;
    int d;
    if (!m_primed) begin
      m_primed = 1;
    end else begin
      d = (c - m_prev + 8) % 8;
      if (d == 1) begin
        m_dir = 1;
        if (m_prev == 7) begin
          wu = 1;
          m_laps = m_laps + 8'd1;
        end
      end else if (d == 7) begin
        m_dir = 0;
        if (m_prev == 0) begin
          wd = 1;
          m_laps = m_laps - 8'd1;
        end
      end else if (d != 0) begin
        bad = 1;
      end
    end
    m_prev = c;
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
    push_state(wu, wd);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, ".primed"},    32'(primed),    32'(e.primed));
      check({tag, ".dir"},       32'(dir),       32'(e.dir));
      check({tag, ".wrap_up"},   32'(wrap_up),   32'(e.wu));
      check({tag, ".wrap_down"}, 32'(wrap_down), 32'(e.wd));
      check({tag, ".laps"},      32'(laps),      32'(e.laps));
      check({tag, ".step_err"},  32'(step_err),  32'(e.err));
    end
  endtask

  // Drive now (between edges), predict, then sample 1 time unit after the edge.
  task automatic step_now(input string tag, input int c, input bit clr);
    count   = CW'(c);
    clr_err = clr;
    model_edge(c, clr);
    @(posedge clk);
    #1;
    compare_out(tag);
    clr_err = 1'b0;
  endtask

  task automatic step(input string tag, input int c, input bit clr = 0);
    @(negedge clk);
    step_now(tag, c, clr);
  endtask

  // Async reset between edges, check outputs at once, release and prime with c.
  task automatic do_reset(input string tag, input int c);
    reset = 1'b0;
    model_reset();
    #1;
    compare_out({tag, ".in_reset"});
    @(negedge clk);
    reset = 1'b1;
    step_now({tag, ".prime"}, c, 0);
  endtask

  initial begin
    #2;
    do_reset("rst0", 0);

    // Up run 0..7,0,1
    for (int v = 1; v <= 7; v++) step("up", v);
    step("up_wrap", 0);
    step("up", 1);
    check("up.final_laps", 32'(laps), 32'h01);
    check("up.final_dir", 32'(dir), 32'd1);

    // Down run from a fresh primed 0
    do_reset("rst_down", 0);
    for (int v = 7; v >= 0; v--) step("down", v);
    step("down_wrap2", 7);
    check("down.final_laps", 32'(laps), 32'hFE);
    check("down.final_err", 32'(step_err), 32'd0);

    // Hold and reversal
    for (int v = 6; v >= 3; v--) step("to3", v);
    step("hold", 3);
    step("hold", 3);
    step("rev_up", 4);
    check("rev.dir_up", 32'(dir), 32'd1);
    step("rev_down", 3);
    check("rev.dir_down", 32'(dir), 32'd0);
    check("hold.laps", 32'(laps), 32'hFE);

    // Illegal jump, sticky, clear, then set-wins-over-clear
    step("to2", 2);
    step("jump", 5);
    check("jump.err", 32'(step_err), 32'd1);
    step("sticky", 6);
    step("sticky", 7);
    step("clear", 7, 1);
    check("clear.err", 32'(step_err), 32'd0);
    for (int v = 6; v >= 2; v--) step("to2b", v);
    step("jump_clr", 5, 1);
    check("jump_clr.err", 32'(step_err), 32'd1);

    // Mid-operation reset with laps=3, dir=1
    do_reset("rst_mid_a", 7);
    for (int l = 0; l < 3; l++)
      for (int v = 0; v <= 7; v++) step("laps3", v);
    check("mid.laps_before", 32'(laps), 32'h03);
    check("mid.dir_before", 32'(dir), 32'd1);
    do_reset("rst_mid", 7);
    check("mid.no_wrap_on_prime", 32'(wrap_up), 32'd0);
    step("mid_wrap", 0);
    check("mid.wrap_up", 32'(wrap_up), 32'd1);
    check("mid.laps_after", 32'(laps), 32'h01);

    // Accumulator wrap: 128 up-laps
    do_reset("rst_acc", 7);
    for (int l = 0; l < 128; l++)
      for (int v = 0; v <= 7; v++) step("acc", v);
    check("acc.laps", 32'(laps), 32'h80);
    check("acc.err", 32'(step_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
